// File: rtl/l1_mmu_line_server.sv
// MMU-side responder for the L1 dcache: serialises line fills and write-backs into
// 32-bit memory beats and forwards MMIO word accesses, one transaction at a time.
`timescale 1ns/1ps
module l1_mmu_line_server #(
  parameter int          LINE_WORDS   = 8,
  parameter int          MMIO_TIMEOUT = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
  parameter logic [3:0]  MMIO_REGION  = 4'hF
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     l1_mmu_req_read,
  input  logic                     l1_mmu_req_write,
  input  logic [31:0]              l1_mmu_req_addr,
  input  logic [32*LINE_WORDS-1:0] l1_mmu_write_data,
  output logic                     mmu_l1_done,
  output logic [32*LINE_WORDS-1:0] mmu_l1_read_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     mmio_read,
  output logic                     mmio_write,
  output logic [31:0]              mmio_addr,
  output logic [31:0]              mmio_wdata,
  input  logic                     mmio_ready,
  input  logic [31:0]              mmio_rdata,
  output logic [2:0]               dbg_state_o
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;
  localparam int LW  = 32 * LINE_WORDS;
  localparam int TW  = $clog2(MMIO_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LINE_RD  = 3'd1,
    LINE_WR  = 3'd2,
    MMIO_ACC = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Handshakes: the cache holds req_read/req_write until the one-cycle done pulse;
  // mem_req/mmio strobes stay high until mem_ack/mmio_ready, which complete the
  // beat/access in the same cycle together with their read data.

  state_t          state_q, state_d;
  logic            cool_q, cool_d;
  logic            mmio_wr_q, mmio_wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [LW-1:0]   wdata_q, wdata_d;
  logic [LW-1:0]   rdata_q, rdata_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [TW-1:0]   timer_q, timer_d;

  function automatic logic addr_is_mmio(input logic [31:0] a);
    return a[31:28] == MMIO_REGION;
  endfunction

  always_comb begin
    state_d     = state_q;
    cool_d      = 1'b0;
    mmio_wr_d   = mmio_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    beat_d      = beat_q;
    timer_d     = timer_q;
    mmu_l1_done = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mmio_read   = 1'b0;
    mmio_write  = 1'b0;
    case (state_q)
      IDLE: begin
        // cool_q gives the cache one cycle to update its metadata after done
        if (!cool_q && (l1_mmu_req_write || l1_mmu_req_read)) begin
          addr_d    = l1_mmu_req_addr;
          wdata_d   = l1_mmu_write_data;
          beat_d    = '0;
          timer_d   = '0;
          mmio_wr_d = l1_mmu_req_write;
          if (addr_is_mmio(l1_mmu_req_addr)) state_d = MMIO_ACC;
          else if (l1_mmu_req_write)         state_d = LINE_WR;
          else                               state_d = LINE_RD;
        end
      end
      LINE_RD, LINE_WR: begin
        mem_req = 1'b1;
        mem_we  = (state_q == LINE_WR);
        if (mem_ack) begin
          if (state_q == LINE_RD) rdata_d[32*beat_q +: 32] = mem_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(LINE_WORDS - 1)) state_d = DONE;
        end
      end
      MMIO_ACC: begin
        mmio_read  = !mmio_wr_q;
        mmio_write = mmio_wr_q;
        if (mmio_ready) begin
          rdata_d = mmio_wr_q ? '0 : {{(LW-32){1'b0}}, mmio_rdata};
          state_d = DONE;
        end else if (timer_q == TW'(MMIO_TIMEOUT)) begin
          rdata_d = mmio_wr_q ? '0 : {{(LW-32){1'b0}}, TIMEOUT_DATA};
          state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        mmu_l1_done = 1'b1;
        cool_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cool_q    <= 1'b0;
      mmio_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      beat_q    <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      cool_q    <= cool_d;
      mmio_wr_q <= mmio_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      beat_q    <= beat_d;
      timer_q   <= timer_d;
    end
  end

  assign mmu_l1_read_data = rdata_q;
  assign mem_addr         = {addr_q[31:OFF], beat_q, 2'b00};
  assign mem_wdata        = wdata_q[32*beat_q +: 32];
  assign mmio_addr        = addr_q;
  assign mmio_wdata       = wdata_q[31:0];
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_l1_mmu_line_server.sv
// Scoreboard bench for l1_mmu_line_server: directed scenarios plus random
// transactions checked against a transaction-level model of the cache/MMU link.
`timescale 1ns/1ps
module tb_l1_mmu_line_server;
  localparam int          LW = 8;
  localparam int          TO = 255;
  localparam logic [31:0] TD = 32'hDEAD_BEEF;

  // clock / reset
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          l1_mmu_req_read = 1'b0, l1_mmu_req_write = 1'b0;
  logic [31:0]   l1_mmu_req_addr = '0;
  logic [255:0]  l1_mmu_write_data = '0;
  logic          mmu_l1_done;
  logic [255:0]  mmu_l1_read_data;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mmio_read, mmio_write, mmio_ready;
  logic [31:0]   mmio_addr, mmio_wdata, mmio_rdata;
  logic [2:0]    dbg_state;

  l1_mmu_line_server dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .l1_mmu_req_read(l1_mmu_req_read), .l1_mmu_req_write(l1_mmu_req_write),
    .l1_mmu_req_addr(l1_mmu_req_addr), .l1_mmu_write_data(l1_mmu_write_data),
    .mmu_l1_done(mmu_l1_done), .mmu_l1_read_data(mmu_l1_read_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_ready(mmio_ready), .mmio_rdata(mmio_rdata),
    .dbg_state_o(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model state
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [255:0] exp_q[$];
  beat_t        beat_q[$];
  logic [255:0] last_rd = '0;
  int           exp_cyc;

  // responder configuration
  int          mem_dly = 0;
  bit          mem_pat = 1'b0;
  int          mmio_dly = 0;
  bit          mmio_never = 1'b0;
  logic [31:0] mmio_data = '0;
  bit          exp_mmio_wr;
  logic [31:0] exp_mmio_addr, exp_mmio_wdata;
  int          ack_cnt = 0;
  int          done_cnt = 0;

  function automatic logic [31:0] resp_word(input logic [31:0] a);
    if (mem_pat) return 32'hA0 + {29'd0, a[4:2]};
    return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  // driver tasks
  task automatic start_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] data);
    logic [31:0]  base;
    logic [255:0] line;
    beat_t        b;
    base = {addr[31:5], 5'b0};
    if (is_mmio(addr)) begin
      exp_mmio_wr    = wr;
      exp_mmio_addr  = addr;
      exp_mmio_wdata = data[31:0];
      if (wr)              line = '0;
      else if (mmio_never) line = {224'd0, TD};
      else                 line = {224'd0, mmio_data};
      exp_cyc = mmio_never ? TO + 2 : mmio_dly + 2;
    end else begin
      line = last_rd;
      for (int i = 0; i < LW; i++) begin
        b.we   = wr;
        b.addr = base + 32'(4 * i);
        b.data = wr ? data[32*i +: 32] : 32'h0;
        beat_q.push_back(b);
        if (!wr) line[32*i +: 32] = resp_word(b.addr);
      end
      exp_cyc = 1 + LW * (mem_dly + 1);
    end
    last_rd = line;
    exp_q.push_back(line);
    l1_mmu_req_read   = rd;
    l1_mmu_req_write  = wr;
    l1_mmu_req_addr   = addr;
    l1_mmu_write_data = data;
  endtask

  task automatic wait_done(input bit scramble, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(posedge sys_clk);
      cyc++;
      if (scramble && cyc == 1) begin
        #1;
        l1_mmu_req_addr   = $urandom;
        l1_mmu_write_data = {8{$urandom}};
      end
      @(negedge sys_clk);
      if (mmu_l1_done) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
  endtask

  task automatic release_req();
    @(posedge sys_clk);
    #1;
    l1_mmu_req_read  = 1'b0;
    l1_mmu_req_write = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_txn(input string name, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [255:0] data);
    int cyc;
    start_txn(rd, wr, addr, data);
    wait_done(1'b1, cyc);
    chk({name, "_latency"}, 256'(cyc), 256'(exp_cyc));
    release_req();
  endtask

  // memory responder: checks each accepted beat against the expected beat order
  initial begin
    int    wc;
    beat_t act;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wc = 0;
    forever begin
      @(negedge sys_clk);
      if (rst_n && mem_req) begin
        if (wc >= mem_dly) begin
          wc = 0;
          mem_ack = 1'b1;
          mem_rdata = resp_word(mem_addr);
          ack_cnt++;
          act.we   = mem_we;
          act.addr = mem_addr;
          act.data = mem_we ? mem_wdata : 32'h0;
          if (beat_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_unexpected: got %0h expected no beat", act);
          end else begin
            chk("mem_beat", 256'(act), 256'(beat_q.pop_front()));
          end
        end else begin
          wc++;
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        wc = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // MMIO responder
  initial begin
    int mc;
    mmio_ready = 1'b0;
    mmio_rdata = '0;
    mc = 0;
    forever begin
      @(negedge sys_clk);
      if (rst_n && (mmio_read || mmio_write)) begin
        if (!mmio_never && mc >= mmio_dly) begin
          mc = 0;
          mmio_ready = 1'b1;
          mmio_rdata = mmio_data;
          chk("mmio_dir", 256'({mmio_write, mmio_read}), exp_mmio_wr ? 256'd2 : 256'd1);
          chk("mmio_addr", 256'(mmio_addr), 256'(exp_mmio_addr));
          if (exp_mmio_wr) chk("mmio_wdata", 256'(mmio_wdata), 256'(exp_mmio_wdata));
        end else begin
          mc++;
          mmio_ready = 1'b0;
          mmio_rdata = $urandom;
        end
      end else begin
        mc = 0;
        mmio_ready = 1'b0;
      end
    end
  end

  // monitor: pops the expected read_data on every done pulse
  initial begin
    bit prev_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rst_n && mmu_l1_done) begin
        done_cnt++;
        chk("done_width", 256'(prev_done), 256'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_unexpected: got done expected none");
        end else begin
          chk("read_data", mmu_l1_read_data, exp_q.pop_front());
        end
      end
      prev_done = rst_n && mmu_l1_done;
    end
  end

  initial begin
    int cyc;
    int d0;
    int a0;
    logic [255:0] line;
    for (int i = 0; i < LW; i++) line[32*i +: 32] = 32'h1111_0000 + 32'(i * 32'h101);

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outs", 256'({mmu_l1_done, mem_req, mem_we, mmio_read, mmio_write}), 256'd0);
    chk("reset_data", mmu_l1_read_data, 256'd0);
    chk("reset_addr", 256'({mem_addr, mem_wdata, mmio_addr, mmio_wdata}), 256'd0);
    chk("reset_state", 256'(dbg_state), 256'd0);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // line fill with the 0xA0+i pattern, ack every cycle
    mem_pat = 1'b1;
    mem_dly = 0;
    run_txn("fill", 1'b1, 1'b0, 32'h0000_1234, {8{$urandom}});
    mem_pat = 1'b0;

    // write-back with 3-cycle ack delay per beat
    mem_dly = 3;
    run_txn("wb", 1'b0, 1'b1, 32'h0000_8040, line);

    // flush then fill on the same index
    mem_dly = 0;
    d0 = done_cnt;
    start_txn(1'b0, 1'b1, 32'h0000_3040, ~line);
    wait_done(1'b1, cyc);
    chk("flush_latency", 256'(cyc), 256'(exp_cyc));
    start_txn(1'b1, 1'b0, 32'h0000_3040, '0);
    wait_done(1'b0, cyc);
    chk("fill_after_flush", 256'(cyc), 256'(exp_cyc + 2));
    release_req();
    chk("flush_done_count", 256'(done_cnt - d0), 256'd2);

    // MMIO read, ready after 5 cycles
    mmio_dly = 5;
    mmio_data = 32'h55;
    run_txn("mmio_rd", 1'b1, 1'b0, 32'hF000_0010, {8{$urandom}});
    // both requests together take the write path
    mmio_dly = 2;
    run_txn("mmio_both", 1'b1, 1'b1, 32'hF000_0024, {8{32'hCAFE_0001}});
    run_txn("line_both", 1'b1, 1'b1, 32'h0000_5000, line);

    // MMIO timeouts
    mmio_never = 1'b1;
    run_txn("mmio_to_rd", 1'b1, 1'b0, 32'hF000_0100, '0);
    run_txn("mmio_to_wr", 1'b0, 1'b1, 32'hF000_0104, {8{32'h1234_5678}});
    mmio_never = 1'b0;
    mmio_data = 32'h0BAD_F00D;
    mmio_dly = 0;
    run_txn("mmio_rd0", 1'b1, 1'b0, 32'hF000_0200, '0);

    // reset during beat 4 of a fill
    mem_dly = 0;
    a0 = ack_cnt;
    start_txn(1'b1, 1'b0, 32'h0000_2200, '0);
    for (int k = 0; k < 100 && ack_cnt < a0 + 4; k++) begin
      @(posedge sys_clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 256'({mem_req, mmu_l1_done, mmio_read, mmio_write}), 256'd0);
    chk("rst_mid_data", mmu_l1_read_data, 256'd0);
    void'(exp_q.pop_back());
    beat_q.delete();
    last_rd = '0;
    l1_mmu_req_read = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    run_txn("fill_after_rst", 1'b1, 1'b0, 32'h0000_2200, '0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int          kind;
      bit          rd, wr;
      logic [31:0] addr;
      kind = $urandom_range(0, 3);
      addr = (kind >= 2) ? {4'hF, 28'($urandom)} : {4'($urandom_range(0, 14)), 28'($urandom)};
      wr = (kind == 1 || kind == 3);
      rd = !wr || ($urandom_range(0, 3) == 0);
      mem_dly = $urandom_range(0, 3);
      mmio_dly = $urandom_range(0, 8);
      mmio_data = $urandom;
      run_txn("rand", rd, wr, addr, {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom});
    end

    repeat (5) @(posedge sys_clk);
    #1;
    chk("exp_q_drained", 256'(exp_q.size()), 256'd0);
    chk("beat_q_drained", 256'(beat_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
